// File: rtl/ubus_slave_mem.sv
// ubus_slave_mem: memory-backed UBUS slave responder. Decodes a fixed byte
// window and serves 1/2/4/8-beat read/write bursts from an internal byte
// array. It inserts WAIT_STATES wait cycles before every beat and gives a
// one-cycle error response to bursts that start inside the window but run
// past its end. All shared bus signals are released (Z) outside its own
// data/error phases.
//
// state | meaning
// IDLE  | waiting for an arbitration phase (ubus_start)
// ADDR  | address phase: sample addr/size/direction and decode
// DATA  | selected transfer: wait cycles, then one beat, repeated
// ERR   | one-cycle error response, then release the bus
module ubus_slave_mem #(
    parameter logic [15:0] BASE_ADDR   = 16'h8000,
    parameter int          MEM_DEPTH   = 256,
    parameter int          WAIT_STATES = 1
) (
    input  logic        ubus_clock,
    input  logic        ubus_reset,
    input  logic        ubus_start,
    input  logic [15:0] ubus_addr,
    input  logic [1:0]  ubus_size,
    input  logic        ubus_read,
    input  logic        ubus_write,
    input  logic        ubus_bip,
    inout  wire  [7:0]  ubus_data,
    output wire         ubus_wait,
    output wire         ubus_error
);

    localparam int          AW     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [2:0]  WS     = 3'(WAIT_STATES);
    // Window bounds at 17 bits so a window touching 16'hFFFF cannot wrap.
    localparam logic [16:0] WIN_LO = 17'(int'(BASE_ADDR));
    localparam logic [16:0] WIN_HI = 17'(int'(BASE_ADDR) + MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t         state, state_d;
    logic           dir_wr, dir_wr_d;
    logic [AW-1:0]  off, off_d;
    logic [3:0]     beats_left, beats_left_d;
    logic [2:0]     wait_cnt, wait_cnt_d;
    logic           mem_we;

    logic [7:0]     mem [MEM_DEPTH];

    logic           rd_req, wr_req, bip_low;
    logic [3:0]     req_beats;
    logic [16:0]    start17, last17;
    logic           in_window, overrun;
    logic           beat_cycle;

    // Control inputs count as asserted only for a clean 1 (X/Z ignored).
    always_comb begin
        rd_req  = 1'b0;
        wr_req  = 1'b0;
        bip_low = 1'b0;
        case (ubus_read)
            1'b1:    rd_req = 1'b1;
            default: ;
        endcase
        case (ubus_write)
            1'b1:    wr_req = 1'b1;
            default: ;
        endcase
        case (ubus_bip)
            1'b0:    bip_low = 1'b1;
            default: ;
        endcase
    end

    assign req_beats  = 4'd1 << ubus_size;
    assign start17    = {1'b0, ubus_addr};
    assign last17     = start17 + {13'd0, req_beats} - 17'd1;
    assign in_window  = (start17 >= WIN_LO) && (start17 <= WIN_HI);
    assign overrun    = (last17 > WIN_HI) || (last17 > 17'h0FFFF);
    assign beat_cycle = (state == DATA) && (wait_cnt == 3'd0);

    // Next-state and datapath update decode.
    always_comb begin
        state_d      = state;
        dir_wr_d     = dir_wr;
        off_d        = off;
        beats_left_d = beats_left;
        wait_cnt_d   = wait_cnt;
        mem_we       = 1'b0;
        case (state)
            IDLE: begin
                if (ubus_start == 1'b1) begin
                    state_d = ADDR;
                end
            end
            ADDR: begin
                state_d = IDLE;
                if ((rd_req != wr_req) && in_window) begin
                    if (overrun) begin
                        state_d = ERR;
                    end else begin
                        state_d      = DATA;
                        dir_wr_d     = wr_req;
                        off_d        = AW'(ubus_addr - BASE_ADDR);
                        beats_left_d = req_beats;
                        wait_cnt_d   = WS;
                    end
                end
            end
            DATA: begin
                if (wait_cnt != 3'd0) begin
                    wait_cnt_d = wait_cnt - 3'd1;
                end else begin
                    mem_we       = dir_wr;
                    off_d        = off + 1'b1;
                    beats_left_d = beats_left - 4'd1;
                    wait_cnt_d   = WS;
                    if (bip_low || (beats_left == 4'd1)) begin
                        state_d = IDLE;
                    end
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and transfer registers; reset drops straight back to IDLE.
    always_ff @(posedge ubus_clock or posedge ubus_reset) begin
        if (ubus_reset) begin
            state      <= IDLE;
            dir_wr     <= 1'b0;
            off        <= '0;
            beats_left <= 4'd0;
            wait_cnt   <= 3'd0;
        end else begin
            state      <= state_d;
            dir_wr     <= dir_wr_d;
            off        <= off_d;
            beats_left <= beats_left_d;
            wait_cnt   <= wait_cnt_d;
        end
    end

    // Byte array write on the closing edge of a write beat; never cleared.
    always_ff @(posedge ubus_clock) begin
        if (mem_we) begin
            mem[off] <= ubus_data;
        end
    end

    // Outputs decode only from registers, so they are released the moment
    // reset forces the FSM to IDLE.
    assign ubus_wait  = (state == DATA || state == ERR) ? (state == DATA && wait_cnt != 3'd0) : 1'bz;
    assign ubus_error = (state == DATA || state == ERR) ? (state == ERR) : 1'bz;
    assign ubus_data  = (beat_cycle && !dir_wr) ? mem[off] : 8'bz;

endmodule

// File: tb/tb_ubus_slave_mem.sv
// Testbench for ubus_slave_mem. Each WAIT_STATES setting (0 and 1) gets two
// DUT copies with identical stimulus, one whose bus nets are pulled up and
// one pulled down: a released signal reads 1 on the first and 0 on the
// second, a driven one reads the same on both.
`timescale 1ns/1ps
module tb_ubus_slave_mem;

    localparam logic [15:0] BASE = 16'h8000;
    localparam int          DEPTH = 256;

    localparam logic [1:0] CZ  = 2'd2;
    localparam logic [8:0] DZ  = 9'h100;

    typedef struct packed {
        logic [1:0] w;
        logic [1:0] e;
        logic [8:0] d;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  start;
    logic [15:0] addr;
    logic [1:0]  size;
    logic        rd, wr, bip;
    logic        den;
    logic [7:0]  dout;

    wire         w0u, w0d, w1u, w1d, e0u, e0d, e1u, e1d;
    wire [7:0]   d0u, d0d, d1u, d1d;

    pullup   pw0u (w0u);
    pulldown pw0d (w0d);
    pullup   pw1u (w1u);
    pulldown pw1d (w1d);
    pullup   pe0u (e0u);
    pulldown pe0d (e0d);
    pullup   pe1u (e1u);
    pulldown pe1d (e1d);
    pullup   pd0u (d0u);
    pulldown pd0d (d0d);
    pullup   pd1u (d1u);
    pulldown pd1d (d1d);

    assign d0u = den ? dout : 8'bz;
    assign d0d = den ? dout : 8'bz;
    assign d1u = den ? dout : 8'bz;
    assign d1d = den ? dout : 8'bz;

    ubus_slave_mem #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u0u (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(start[0]), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(rd), .ubus_write(wr), .ubus_bip(bip),
        .ubus_data(d0u), .ubus_wait(w0u), .ubus_error(e0u));
    ubus_slave_mem #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(0)) u0d (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(start[0]), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(rd), .ubus_write(wr), .ubus_bip(bip),
        .ubus_data(d0d), .ubus_wait(w0d), .ubus_error(e0d));
    ubus_slave_mem #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u1u (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(start[1]), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(rd), .ubus_write(wr), .ubus_bip(bip),
        .ubus_data(d1u), .ubus_wait(w1u), .ubus_error(e1u));
    ubus_slave_mem #(.BASE_ADDR(BASE), .MEM_DEPTH(DEPTH), .WAIT_STATES(1)) u1d (
        .ubus_clock(clk), .ubus_reset(rst), .ubus_start(start[1]), .ubus_addr(addr),
        .ubus_size(size), .ubus_read(rd), .ubus_write(wr), .ubus_bip(bip),
        .ubus_data(d1d), .ubus_wait(w1d), .ubus_error(e1d));

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    obs_t        exp_q[$];
    obs_t        obs_q[$];
    logic [7:0]  model [2][DEPTH];
    logic [7:0]  wbuf [8];

    function automatic logic [1:0] code1(input logic pu, input logic pd);
        if (pu === 1'b1 && pd === 1'b0) return CZ;
        if (pu === pd && (pu === 1'b0 || pu === 1'b1)) return {1'b0, pu};
        return 2'd3;
    endfunction

    function automatic logic [8:0] code8(input logic [7:0] pu, input logic [7:0] pd);
        if (pu === 8'hFF && pd === 8'h00) return DZ;
        if (pu === pd) return {1'b0, pu};
        return 9'h1FF;
    endfunction

    function automatic obs_t sample(input int ws);
        obs_t o;
        if (ws == 0) begin
            o.w = code1(w0u, w0d); o.e = code1(e0u, e0d); o.d = code8(d0u, d0d);
        end else begin
            o.w = code1(w1u, w1d); o.e = code1(e1u, e1d); o.d = code8(d1u, d1d);
        end
        return o;
    endfunction

    function automatic obs_t mk(input logic [1:0] w, input logic [1:0] e, input logic [8:0] d);
        obs_t o;
        o.w = w; o.e = e; o.d = d;
        return o;
    endfunction

    // One bus cycle: drive has already happened; sample mid-cycle.
    task automatic cyc_end(input int ws, input obs_t e);
        exp_q.push_back(e);
        @(negedge clk);
        obs_q.push_back(sample(ws));
    endtask

    // Runs one UBUS transfer on the selected pair, pushing per-cycle
    // expectations from the bench's own decode and memory model.
    task automatic txn(input int ws, input logic [15:0] a, input logic [1:0] sz,
                       input logic r, input logic w, input int drop_beat, input int rst_beat);
        int  nb, st, last, o;
        bit  rq, wq, valid, inwin, err, sel;
        nb    = 1 << sz;
        rq    = (r === 1'b1);
        wq    = (w === 1'b1);
        valid = rq ^ wq;
        st    = int'(a);
        last  = st + nb - 1;
        inwin = (st >= int'(BASE)) && (st <= int'(BASE) + DEPTH - 1);
        err   = valid && inwin && ((last > int'(BASE) + DEPTH - 1) || (last > 65535));
        sel   = valid && inwin && !err;

        @(posedge clk); #1;
        start[ws] = 1'b1;
        cyc_end(ws, mk(CZ, CZ, DZ));
        @(posedge clk); #1;
        start = 2'b00; addr = a; size = sz; rd = r; wr = w;
        cyc_end(ws, mk(CZ, CZ, DZ));
        @(posedge clk); #1;
        addr = 16'h0; size = 2'd0; rd = 1'b0; wr = 1'b0;

        if (err) begin
            cyc_end(ws, mk(2'd0, 2'd1, DZ));
        end else if (sel) begin
            for (int n = 0; n < nb; n++) begin
                o   = st - int'(BASE) + n;
                bip = (n == nb - 1 || n == drop_beat) ? 1'b0 : 1'b1;
                for (int k = 0; k < ws; k++) begin
                    den = 1'b0;
                    cyc_end(ws, mk(2'd1, 2'd0, DZ));
                    @(posedge clk); #1;
                end
                den  = wq;
                dout = wbuf[n];
                cyc_end(ws, mk(2'd0, 2'd0, wq ? {1'b0, wbuf[n]} : {1'b0, model[ws][o]}));
                if (wq) model[ws][o] = wbuf[n];
                @(posedge clk); #1;
                den = 1'b0;
                bip = 1'b0;
                if (n == rst_beat) begin
                    rst = 1'b1;
                    cyc_end(ws, mk(CZ, CZ, DZ));
                    @(posedge clk); #1;
                    rst = 1'b0;
                    return;
                end
                if (n == drop_beat) break;
            end
        end
        cyc_end(ws, mk(CZ, CZ, DZ));
        @(posedge clk); #1;
        cyc_end(ws, mk(CZ, CZ, DZ));
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1; start = 2'b00; addr = 16'h0; size = 2'd0;
        rd = 1'b0; wr = 1'b0; bip = 1'b0; den = 1'b0; dout = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int ws = 0; ws < 2; ws++) begin
            o = sample(ws);
            vectors++;
            if (o !== mk(CZ, CZ, DZ)) begin
                miscompares++;
                $display("FAIL reset ws%0d: got w=%0d e=%0d d=%h, want all released", ws, o.w, o.e, o.d);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single_ws0();
        obs_t e, o;
        wbuf[0] = 8'hA5;
        txn(0, 16'h8010, 2'd0, 1'b0, 1'b1, -1, -1);
        txn(0, 16'h8010, 2'd0, 1'b1, 1'b0, -1, -1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL single_ws0 cyc%0d: got w=%0d e=%0d d=%h, want w=%0d e=%0d d=%h", i, o.w, o.e, o.d, e.w, e.e, e.d);
            end
        end
    endtask

    task automatic test_burst_ws1();
        obs_t e, o;
        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33; wbuf[3] = 8'h44;
        txn(1, 16'h8020, 2'd2, 1'b0, 1'b1, -1, -1);
        txn(1, 16'h8020, 2'd2, 1'b1, 1'b0, -1, -1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL burst_ws1 cyc%0d: got w=%0d e=%0d d=%h, want w=%0d e=%0d d=%h", i, o.w, o.e, o.d, e.w, e.e, e.d);
            end
        end
    endtask

    task automatic test_error();
        obs_t e, o;
        wbuf[0] = 8'hC0; wbuf[1] = 8'hC1; wbuf[2] = 8'hC2; wbuf[3] = 8'hC3;
        txn(1, 16'h80FC, 2'd2, 1'b0, 1'b1, -1, -1);
        txn(1, 16'h80FC, 2'd3, 1'b1, 1'b0, -1, -1);
        wbuf = '{8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE, 8'hEE};
        txn(1, 16'h80FE, 2'd2, 1'b0, 1'b1, -1, -1);
        txn(1, 16'h80FC, 2'd2, 1'b1, 1'b0, -1, -1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL error cyc%0d: got w=%0d e=%0d d=%h, want w=%0d e=%0d d=%h", i, o.w, o.e, o.d, e.w, e.e, e.d);
            end
        end
    endtask

    task automatic test_unselected();
        obs_t e, o;
        txn(1, 16'h4000, 2'd1, 1'b1, 1'b0, -1, -1);
        txn(1, 16'h8010, 2'd1, 1'b0, 1'b0, -1, -1);
        txn(1, 16'h8010, 2'd1, 1'bz, 1'bz, -1, -1);
        txn(1, 16'h8010, 2'd1, 1'b1, 1'b1, -1, -1);
        txn(1, 16'h8100, 2'd0, 1'b1, 1'b0, -1, -1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL unselected cyc%0d: got w=%0d e=%0d d=%h, want w=%0d e=%0d d=%h", i, o.w, o.e, o.d, e.w, e.e, e.d);
            end
        end
    endtask

    task automatic test_reset_abort();
        obs_t e, o;
        wbuf[0] = 8'h5A;
        txn(1, 16'h8043, 2'd0, 1'b0, 1'b1, -1, -1);
        wbuf = '{8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77, 8'h78};
        txn(1, 16'h8040, 2'd3, 1'b0, 1'b1, -1, 2);
        txn(1, 16'h8040, 2'd2, 1'b1, 1'b0, -1, -1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL reset_abort cyc%0d: got w=%0d e=%0d d=%h, want w=%0d e=%0d d=%h", i, o.w, o.e, o.d, e.w, e.e, e.d);
            end
        end
    endtask

    task automatic test_bip_drop();
        obs_t e, o;
        txn(1, 16'h8020, 2'd2, 1'b1, 1'b0, 1, -1);
        txn(1, 16'h8022, 2'd0, 1'b1, 1'b0, -1, -1);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL bip_drop cyc%0d: got w=%0d e=%0d d=%h, want w=%0d e=%0d d=%h", i, o.w, o.e, o.d, e.w, e.e, e.d);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_ws0();
        test_burst_ws1();
        test_error();
        test_unselected();
        test_reset_abort();
        test_bip_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
